// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared types and constants for the intersection controller and its input conditioner
package traffic_pkg;

  typedef enum logic [2:0] {
    G_IDLE   = 3'd0,
    G_IN_A   = 3'd1,
    G_IN_AB  = 3'd2,
    G_IN_B   = 3'd3,
    G_OUT_B  = 3'd4,
    G_OUT_AB = 3'd5,
    G_OUT_A  = 3'd6
  } gate_state_t;

  // Registered gate result; one-hot decode keeps enter/exit/fault mutually exclusive.
  typedef enum logic [1:0] {
    GEV_NONE  = 2'd0,
    GEV_ENTER = 2'd1,
    GEV_EXIT  = 2'd2,
    GEV_FAULT = 2'd3
  } gate_event_t;

  localparam logic [1:0] RED    = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] GREEN  = 2'b10;

endpackage

// File: rtl/debounce_sync.sv
// rtl/debounce_sync.sv - two-flop synchronizer followed by a stable-count debouncer
module debounce_sync #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_raw,
  output logic o_level
);

  localparam logic [3:0] LP_LAST = 4'(DEBOUNCE_CYCLES - 1);

  logic       r_meta;
  logic       r_sync;
  logic       r_level;
  logic [3:0] r_cnt;

  // The level flips on the DEBOUNCE_CYCLES-th consecutive differing synced sample.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_meta  <= 1'b0;
      r_sync  <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_meta <= i_raw;
      r_sync <= r_meta;
      if (r_sync == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == LP_LAST) begin
        r_level <= r_sync;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/traffic_input_conditioner.sv
// rtl/traffic_input_conditioner.sv - conditions raw field inputs into controller requests
// (pedestrian latch, emergency stretch, parking gate sequence decode).
module traffic_input_conditioner
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int EMERG_HOLD      = 8,
  parameter int GATE_TIMEOUT    = 15
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_vehicle_loop_raw,
  input  logic i_ped_button_raw,
  input  logic i_siren_raw,
  input  logic i_gate_loop_a_raw,
  input  logic i_gate_loop_b_raw,
  input  logic i_pedestrian_green,
  input  logic i_emergency_active,
  output logic o_car_sensor,
  output logic o_pedestrian_req,
  output logic o_emergency,
  output logic o_car_enter,
  output logic o_car_exit,
  output logic o_gate_fault,
  output logic o_emerg_served
);

  localparam logic [7:0] LP_HOLD_RELOAD = 8'(EMERG_HOLD - 1);
  localparam logic [7:0] LP_TIMEOUT     = 8'(GATE_TIMEOUT);

  logic w_vehicle;
  logic w_button;
  logic w_siren;
  logic w_loop_a;
  logic w_loop_b;

  debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_vehicle (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_raw(i_vehicle_loop_raw), .o_level(w_vehicle)
  );
  debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_button (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_raw(i_ped_button_raw), .o_level(w_button)
  );
  debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_siren (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_raw(i_siren_raw), .o_level(w_siren)
  );
  debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_loop_a (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_raw(i_gate_loop_a_raw), .o_level(w_loop_a)
  );
  debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_loop_b (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_raw(i_gate_loop_b_raw), .o_level(w_loop_b)
  );

  logic       r_button_prev;
  logic       r_siren_prev;
  logic       r_ped_req;
  logic [7:0] r_hold;
  logic       w_button_rise;
  logic       w_siren_fall;

  assign w_button_rise = w_button & ~r_button_prev;
  assign w_siren_fall  = r_siren_prev & ~w_siren;

  // The fall cycle itself is covered by w_siren_fall, so the counter holds the remaining cycles.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_button_prev <= 1'b0;
      r_siren_prev  <= 1'b0;
      r_ped_req     <= 1'b0;
      r_hold        <= '0;
    end else begin
      r_button_prev <= w_button;
      r_siren_prev  <= w_siren;
      if (i_pedestrian_green) begin
        r_ped_req <= 1'b0;
      end else if (w_button_rise) begin
        r_ped_req <= 1'b1;
      end
      if (w_siren) begin
        r_hold <= '0;
      end else if (w_siren_fall) begin
        r_hold <= LP_HOLD_RELOAD;
      end else if (r_hold != 8'd0) begin
        r_hold <= r_hold - 8'd1;
      end
    end
  end

  assign o_car_sensor     = w_vehicle;
  assign o_pedestrian_req = r_ped_req;
  assign o_emergency      = w_siren | w_siren_fall | (r_hold != 8'd0);
  assign o_emerg_served   = o_emergency & i_emergency_active;

  gate_state_t r_gate_state;
  gate_state_t w_gate_next;
  gate_event_t r_gate_evt;
  gate_event_t w_gate_evt;
  logic [7:0]  r_dwell;
  logic [1:0]  w_ab;

  assign w_ab = {w_loop_a, w_loop_b};

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_gate_state <= G_IDLE;
      r_gate_evt   <= GEV_NONE;
      r_dwell      <= '0;
    end else begin
      r_gate_state <= w_gate_next;
      r_gate_evt   <= w_gate_evt;
      if (w_gate_next != r_gate_state) begin
        r_dwell <= '0;
      end else if (r_gate_state != G_IDLE) begin
        r_dwell <= r_dwell + 8'd1;
      end
    end
  end

  // Each non-idle state either holds on its own loop pattern, advances, or falls back to idle.
  always_comb begin
    w_gate_next = r_gate_state;
    w_gate_evt  = GEV_NONE;
    if (r_gate_state != G_IDLE && r_dwell == LP_TIMEOUT) begin
      w_gate_next = G_IDLE;
      w_gate_evt  = GEV_FAULT;
    end else begin
      case (r_gate_state)
        G_IDLE: begin
          if (w_ab == 2'b10)      w_gate_next = G_IN_A;
          else if (w_ab == 2'b01) w_gate_next = G_OUT_B;
          else if (w_ab == 2'b11) w_gate_evt  = GEV_FAULT;
        end
        G_IN_A: begin
          if (w_ab == 2'b11)      w_gate_next = G_IN_AB;
          else if (w_ab != 2'b10) w_gate_next = G_IDLE;
        end
        G_IN_AB: begin
          if (w_ab == 2'b01)      w_gate_next = G_IN_B;
          else if (w_ab != 2'b11) w_gate_next = G_IDLE;
        end
        G_IN_B: begin
          if (w_ab == 2'b00) begin
            w_gate_next = G_IDLE;
            w_gate_evt  = GEV_ENTER;
          end else if (w_ab != 2'b01) begin
            w_gate_next = G_IDLE;
          end
        end
        G_OUT_B: begin
          if (w_ab == 2'b11)      w_gate_next = G_OUT_AB;
          else if (w_ab != 2'b01) w_gate_next = G_IDLE;
        end
        G_OUT_AB: begin
          if (w_ab == 2'b10)      w_gate_next = G_OUT_A;
          else if (w_ab != 2'b11) w_gate_next = G_IDLE;
        end
        G_OUT_A: begin
          if (w_ab == 2'b00) begin
            w_gate_next = G_IDLE;
            w_gate_evt  = GEV_EXIT;
          end else if (w_ab != 2'b10) begin
            w_gate_next = G_IDLE;
          end
        end
        default: w_gate_next = G_IDLE;
      endcase
    end
  end

  always_comb begin
    o_car_enter  = 1'b0;
    o_car_exit   = 1'b0;
    o_gate_fault = 1'b0;
    case (r_gate_evt)
      GEV_ENTER: o_car_enter  = 1'b1;
      GEV_EXIT:  o_car_exit   = 1'b1;
      GEV_FAULT: o_gate_fault = 1'b1;
      default:   ;
    endcase
  end

endmodule

// File: tb/tb_traffic_input_conditioner.sv
// tb/tb_traffic_input_conditioner.sv - self-checking bench for traffic_input_conditioner
module tb_traffic_input_conditioner;

  localparam int D   = 4;
  localparam int EH  = 8;
  localparam int OFF = 16;
  localparam int NR  = 1500;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, veh, ped, sir, ga, gb, green, active;
  logic car_sensor, ped_req, emerg, car_enter, car_exit, gate_fault, served;

  traffic_input_conditioner dut (
    .i_clk(clk), .i_reset_n(reset_n),
    .i_vehicle_loop_raw(veh), .i_ped_button_raw(ped), .i_siren_raw(sir),
    .i_gate_loop_a_raw(ga), .i_gate_loop_b_raw(gb),
    .i_pedestrian_green(green), .i_emergency_active(active),
    .o_car_sensor(car_sensor), .o_pedestrian_req(ped_req), .o_emergency(emerg),
    .o_car_enter(car_enter), .o_car_exit(car_exit), .o_gate_fault(gate_fault),
    .o_emerg_served(served)
  );

  int checks = 0;
  int errors = 0;
  int n_enter, n_exit, n_fault, n_overlap;

  typedef struct {
    int width;
    int exp_high;
  } glitch_vec_t;

  typedef struct {
    logic [7:0] pats;
    int n_enter;
    int n_exit;
    int n_fault;
  } gate_vec_t;

  glitch_vec_t gv[6];
  gate_vec_t   tv[8];

  logic rv[NR+OFF], rp[NR+OFF], rs[NR+OFF], gr[NR+OFF];
  logic dv[NR+OFF], dp[NR+OFF], ds[NR+OFF], rq[NR+OFF];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (car_enter)  n_enter++;
    if (car_exit)   n_exit++;
    if (gate_fault) n_fault++;
    if (int'(car_enter) + int'(car_exit) + int'(gate_fault) > 1) n_overlap++;
  endtask

  task automatic clear_counts();
    n_enter = 0;
    n_exit  = 0;
    n_fault = 0;
  endtask

  function automatic logic deb_next(input logic prev, input logic [D-1:0] win);
    return (win == {D{~prev}}) ? ~prev : prev;
  endfunction

  initial begin
    int first, high, lows;
    logic [1:0] p;
    logic [D-1:0] wv, wp, ws;
    logic em;
    int v_left, p_left, s_left;

    gv[0] = '{1, 0}; gv[1] = '{2, 0}; gv[2] = '{3, 0};
    gv[3] = '{4, 4}; gv[4] = '{5, 5}; gv[5] = '{9, 9};
    tv[0] = '{8'b10_11_01_00, 1, 0, 0};
    tv[1] = '{8'b01_11_10_00, 0, 1, 0};
    tv[2] = '{8'b10_11_10_00, 0, 0, 0};
    tv[3] = '{8'b01_11_01_00, 0, 0, 0};
    tv[4] = '{8'b10_00_01_00, 0, 0, 0};
    tv[5] = '{8'b10_11_01_01, 1, 0, 0};
    tv[6] = '{8'b01_11_10_10, 0, 1, 0};
    tv[7] = '{8'b10_10_10_00, 0, 0, 1};

    n_overlap = 0;
    clear_counts();
    {veh, ped, sir, ga, gb, green, active} = '0;
    reset_n = 1'b0;
    repeat (3) tick();
    check("reset_outputs", int'({car_sensor, ped_req, emerg, car_enter, car_exit, gate_fault, served}), 0);
    reset_n = 1'b1;
    tick();

    // Vehicle loop glitch filtering and latency.
    for (int r = 0; r < 6; r++) begin
      first = -1;
      high  = 0;
      veh   = 1'b1;
      for (int t = 1; t <= 25; t++) begin
        tick();
        if (t == gv[r].width) veh = 1'b0;
        if (car_sensor) begin
          high++;
          if (first < 0) first = t;
        end
      end
      check($sformatf("veh_w%0d_high", gv[r].width), high, gv[r].exp_high);
      if (gv[r].exp_high > 0) check($sformatf("veh_w%0d_start", gv[r].width), first, 6);
    end

    // Pedestrian request latch and acknowledge.
    ped = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (t == 10) ped = 1'b0;
      if (t == 6) check("ped_req_before", int'(ped_req), 0);
      if (t == 7) check("ped_req_rise", int'(ped_req), 1);
    end
    check("ped_req_held", int'(ped_req), 1);
    green = 1'b1;
    tick();
    green = 1'b0;
    check("ped_req_ack", int'(ped_req), 0);
    tick();
    check("ped_req_stays_clear", int'(ped_req), 0);

    // Emergency stretch.
    sir = 1'b1;
    repeat (20) tick();
    sir = 1'b0;
    active = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (t == 10) begin
        check("served_hi", int'(served), 1);
        active = 1'b0;
        #1;
        check("served_lo", int'(served), 0);
      end
      if (t == 13) check("emerg_hold_last", int'(emerg), 1);
      if (t == 14) check("emerg_hold_end", int'(emerg), 0);
    end
    lows = 0;
    sir = 1'b1;
    for (int t = 1; t <= 45; t++) begin
      tick();
      if (t == 20) sir = 1'b0;
      if (t == 25) sir = 1'b1;
      if (t > 6 && !emerg) lows++;
    end
    check("emerg_rerise_lows", lows, 0);
    sir = 1'b0;
    repeat (20) tick();
    check("emerg_quiet", int'(emerg), 0);

    // Gate sequence table.
    for (int r = 0; r < 8; r++) begin
      clear_counts();
      for (int s = 0; s < 4; s++) begin
        p = tv[r].pats[7-2*s -: 2];
        ga = p[1];
        gb = p[0];
        repeat (6) tick();
      end
      ga = 1'b0;
      gb = 1'b0;
      repeat (14) tick();
      check($sformatf("gate%0d_enter", r), n_enter, tv[r].n_enter);
      check($sformatf("gate%0d_exit", r), n_exit, tv[r].n_exit);
      check($sformatf("gate%0d_fault", r), n_fault, tv[r].n_fault);
    end

    // Gate dwell timeout.
    clear_counts();
    ga = 1'b1;
    for (int t = 1; t <= 45; t++) begin
      tick();
      if (t == 20) ga = 1'b0;
      if (t == 22) check("timeout_pre", int'(gate_fault), 0);
      if (t == 23) check("timeout_pulse", int'(gate_fault), 1);
      if (t == 24) check("timeout_post", int'(gate_fault), 0);
    end
    check("timeout_count", n_fault, 1);
    check("timeout_no_car", n_enter + n_exit, 0);

    // Reset in the middle of an entry sequence with a pending request.
    ped = 1'b1;
    repeat (10) tick();
    ped = 1'b0;
    repeat (2) tick();
    check("mid_req_pending", int'(ped_req), 1);
    ga = 1'b1;
    repeat (6) tick();
    gb = 1'b1;
    repeat (10) tick();
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_reset_outputs", int'({car_sensor, ped_req, emerg, car_enter, car_exit, gate_fault, served}), 0);
    ga = 1'b0;
    gb = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    clear_counts();
    repeat (25) tick();
    check("mid_no_enter", n_enter, 0);
    check("mid_no_fault", n_fault + n_exit, 0);
    check("mid_req_gone", int'(ped_req), 0);

    // Randomized run against a window-based reference model.
    reset_n = 1'b0;
    {veh, ped, sir, green, active} = '0;
    for (int i = 0; i < NR + OFF; i++) begin
      rv[i] = 0; rp[i] = 0; rs[i] = 0; gr[i] = 0;
      dv[i] = 0; dp[i] = 0; ds[i] = 0; rq[i] = 0;
    end
    repeat (2) tick();
    reset_n = 1'b1;
    v_left = 0;
    p_left = 0;
    s_left = 0;
    for (int k = 0; k < NR; k++) begin
      int i;
      i = k + OFF;
      if (v_left == 0) begin veh = ~veh; v_left = $urandom_range(1, 8); end
      v_left--;
      if (p_left == 0) begin ped = ped ? 1'b0 : ($urandom_range(0, 2) == 0); p_left = $urandom_range(2, 14); end
      p_left--;
      if (s_left == 0) begin sir = ~sir; s_left = $urandom_range(1, 24); end
      s_left--;
      green  = ($urandom_range(0, 9) == 0);
      active = $urandom_range(0, 1);
      tick();
      rv[i] = veh; rp[i] = ped; rs[i] = sir; gr[i] = green;
      for (int j = 0; j < D; j++) begin
        wv[j] = rv[i-2-j];
        wp[j] = rp[i-2-j];
        ws[j] = rs[i-2-j];
      end
      dv[i] = deb_next(dv[i-1], wv);
      dp[i] = deb_next(dp[i-1], wp);
      ds[i] = deb_next(ds[i-1], ws);
      rq[i] = gr[i] ? 1'b0 : ((dp[i-1] && !dp[i-2]) ? 1'b1 : rq[i-1]);
      em = 1'b0;
      for (int j = 0; j <= EH; j++) em = em | ds[i-j];
      check($sformatf("rnd%0d_car_sensor", k), int'(car_sensor), int'(dv[i]));
      check($sformatf("rnd%0d_ped_req", k), int'(ped_req), int'(rq[i]));
      check($sformatf("rnd%0d_emergency", k), int'(emerg), int'(em));
      check($sformatf("rnd%0d_served", k), int'(served), int'(em & active));
    end

    check("pulse_overlap", n_overlap, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
